// File: rtl/reg_file_mw.sv
// -----------------------------------------------------------------------------
// reg_file_mw
//
// Pipeline register file with two write ports (dual-issue writeback), two
// combinational read ports (decode) and a sequential clear engine that zeroes
// every entry after reset before the file is released for use.
//
// Parameters
//   XLEN      data width of each register
//   AW        address width; depth NREGS = 2**AW
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//             0: register 0 is an ordinary register
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN)
//   defined   : a read whose address matches a write being accepted in the same
//               cycle returns the write data combinationally (port 1 over
//               port 0 over array contents)
//   undefined : reads return the array contents before the write edge
//
// Ports
//   clk        in   core clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, restarts the clear sequence
//   init_done  out  high once every entry has been cleared; writes accepted
//   we0/wa0/wd0 in  write port 0
//   we1/wa1/wd1 in  write port 1 (wins when both ports target one address)
//   ra1/rd1    in/out  read port A (combinational)
//   ra2/rd2    in/out  read port B (combinational)
//
// Handshake: there is none. Writes are fire-and-forget and only take effect
// while init_done is high; reads are valid only while init_done is high and
// return zero otherwise.
// -----------------------------------------------------------------------------
module reg_file_mw #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    localparam int            NREGS    = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;
    logic [AW-1:0]   clr_cnt_next;

    logic [XLEN-1:0] regs [NREGS];

    logic            clear_active;
    logic            run_active;
    logic            wr0_ok;
    logic            wr1_ok;

    // ------------------------------------------------------------------
    // Clear-engine FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Clear-engine FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            S_CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
            default: begin
                state_next   = S_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // init_done comes straight from the state register, so it rises on the
    // edge that performs the last clear write and is glitch-free.
    assign init_done = (state == S_RUN);

    // The reset cycle itself must leave the array untouched, hence !rst here.
    assign clear_active = (state == S_CLEAR) && !rst;
    assign run_active   = (state == S_RUN)   && !rst;

    // Port 0 is suppressed when port 1 hits the same address so the array
    // sees a single well-defined write per entry per cycle.
    assign wr0_ok = run_active && we0
                 && !((ZERO_REG != 0) && (wa0 == '0))
                 && !(we1 && (wa1 == wa0));
    assign wr1_ok = run_active && we1
                 && !((ZERO_REG != 0) && (wa1 == '0));

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear_active) begin
            regs[clr_cnt] <= '0;
        end else begin
            if (wr0_ok) begin
                regs[wa0] <= wd0;
            end
            if (wr1_ok) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Shared by both read ports. Reads are masked until the clear sequence
    // completes so partially cleared or stale contents never leak out.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (state != S_RUN) begin
            val = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (run_active && we1 && (wa1 == addr)) begin
            val = wd1;
        end else if (run_active && we0 && (wa0 == addr)) begin
            val = wd0;
`endif
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: doc/reg_file_mw.md
Name: reg_file_mw

Overview:
- Parametrised successor to the single-write-port pipeline register file. Adds configurable data width and depth, a second write port for dual-issue writeback, and a sequential post-reset clear engine.
- Optional write-to-read bypass removes the WB→ID forwarding path.
- Sits between the decode stage (reads) and the writeback stage (writes) of the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; depth NREGS = 2**AW.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes; when 0 register 0 is a normal register.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sequence has finished and the file accepts writes.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- ra1  in  AW  read address, port A.
- ra2  in  AW  read address, port B.
- rd1  out  XLEN  read data, port A (combinational from ra1).
- rd2  out  XLEN  read data, port B (combinational from ra2).

Behaviour:
- Reset: one clock; synchronous and active-high (rst sampled on the rising edge of clk). On a clocked rst, the FSM goes to CLEAR, clr_cnt = 0 and init_done = 0. Register contents are not touched in the reset cycle itself.
- FSM states:
  - CLEAR: each cycle writes zero to regs[clr_cnt], then clr_cnt increments. When clr_cnt == NREGS-1 the cycle writes the last entry and the FSM moves to RUN. Takes exactly NREGS cycles after rst deasserts.
  - RUN: init_done = 1 (registered; rises the cycle after the final clear write). Stays in RUN until rst.
- During CLEAR:
  - we0/we1 are ignored (writes dropped, not queued).
  - rd1/rd2 are forced to 0 regardless of address.
- rst asserted mid-CLEAR or in RUN: the sequence restarts from clr_cnt = 0 on the next edge. Partially cleared or stale contents are never visible, because reads are masked until init_done.
- Writes in RUN: on the rising edge, regs[wa0] <= wd0 if we0, and regs[wa1] <= wd1 if we1.
  - Both enabled with wa0 == wa1: port 1 wins; the port 0 data is discarded.
  - ZERO_REG = 1: any write to address 0 is dropped and rd of address 0 returns 0.
- Reads: combinational, zero-cycle latency, from the current array contents (subject to the bypass rule below). Both read ports are independent; ra1 == ra2 is legal.
- Width rules: no truncation or extension; all data paths are XLEN wide. Addresses are full AW, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if a read address matches an enabled write address in the same cycle, rd returns the write data combinationally.
  - Priority: a wa1 match over a wa0 match over array contents.
  - ZERO_REG = 1 with address 0 still returns 0.
  - Bypass is inactive during CLEAR.
- Undefined: reads return pre-write array contents; the new value is visible the cycle after the write edge.

Test Plan:
- rst high 2 cycles, then low with AW=5 → init_done is 0 for 32 cycles and 1 on cycle 33; rd1 = rd2 = 0 throughout; writes issued during CLEAR (we0=1, wa0=7, wd0=0xDEAD) leave reg7 = 0 after init.
- RUN: we0=1 wa0=3 wd0=0x11111111, we1=1 wa1=4 wd1=0x22222222 in one cycle; next cycle ra1=3, ra2=4 → rd1=0x11111111, rd2=0x22222222.
- Write conflict: we0=1, we1=1, wa0=wa1=9, wd0=0xAAAA0000, wd1=0x0000BBBB → reg9 reads 0x0000BBBB.
- ZERO_REG=1: we1=1 wa1=0 wd1=0xFFFFFFFF, then ra1=0 → rd1=0. Repeat with ZERO_REG=0 → rd1=0xFFFFFFFF.
- Mid-operation reset: load reg5=0x12345678, pulse rst for 1 cycle, then run 10 cycles → init_done=0 and rd(ra1=5)=0. After completion, reg5 reads 0.
- Bypass: we0=1 wa0=6 wd0=0xCAFEF00D with ra1=6 in the same cycle → with REGFILE_BYPASS_EN rd1=0xCAFEF00D that cycle; without it rd1 = old value (0), then 0xCAFEF00D next cycle. With both ports writing addr 6 (wd1=0x0BADBEEF), bypass returns 0x0BADBEEF.
